// File: rtl/ysyx_22050598_csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the EXU stage.
// Handles CSR read/modify/write, ecall/mret/timer-interrupt entry and a one-cycle registered redirect.
module ysyx_22050598_csr_trap_unit #(
  parameter int                 XLEN             = 64,
  parameter logic [XLEN-1:0]    MSTATUS_RESETVAL = 64'h0000_000a_0000_1800,
  parameter logic [XLEN-1:0]    MTVEC_RESETVAL   = '0,
  parameter logic [XLEN-1:0]    HARTID           = '0,
  parameter logic [XLEN-1:0]    MISA_VAL         = 64'h8000_0000_0000_0100,
  parameter int                 SYNC_STAGES      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  output logic            ready_o,
  input  logic [5:0]      ex_csr_bus_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_reg_i,
  input  logic [4:0]      csr_zimm_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_inst_is_ecall_i,
  input  logic            ex_inst_is_mret_i,
  input  logic            retire_i,
  input  logic            mtip_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            csr_illegal_o,
  output logic            kill_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam int BIT_MIE  = 3;
  localparam int BIT_MPIE = 7;
  localparam int BIT_MPP  = 11;

  typedef enum logic {IDLE, REDIR} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] mstatus_q, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
  logic [XLEN-1:0] mcycle_q, minstret_q, redirect_pc_q;
  logic            mtie_q;
  logic [SYNC_STAGES-1:0] mtip_sync_q;
  logic            mtip_sync;

  logic            fire, irq_pend, take_irq, take_ecall, take_mret, take_trap, csr_op;
  logic            is_imm, is_write, is_set, is_clear, suppress, addr_hit, wr_en;
  logic [XLEN-1:0] src, old_val, wdata, mtvec_base, trap_target, mie_val, mip_val;

  assign mtip_sync = mtip_sync_q[SYNC_STAGES-1];

  // Control and trap priority: interrupt > ecall > mret > CSR op
  assign fire       = ex_valid_i & ready_o;
  assign irq_pend   = mstatus_q[BIT_MIE] & mtie_q & mtip_sync;
  assign take_irq   = fire & irq_pend;
  assign take_ecall = fire & ~irq_pend & ex_inst_is_ecall_i;
  assign take_mret  = fire & ~irq_pend & ~ex_inst_is_ecall_i & ex_inst_is_mret_i;
  assign take_trap  = take_irq | take_ecall;
  assign csr_op     = fire & ~irq_pend & ~ex_inst_is_ecall_i & ~ex_inst_is_mret_i
                      & (|ex_csr_bus_i);

  assign kill_o = take_irq;

  assign is_imm   = |ex_csr_bus_i[2:0];
  assign is_write = ex_csr_bus_i[5] | ex_csr_bus_i[2];
  assign is_set   = ex_csr_bus_i[4] | ex_csr_bus_i[1];
  assign is_clear = ex_csr_bus_i[3] | ex_csr_bus_i[0];
  assign src      = is_imm ? {{(XLEN-5){1'b0}}, csr_zimm_i} : csr_reg_i;
  assign suppress = (is_set | is_clear) & (src == '0);

  assign mie_val = {{(XLEN-8){1'b0}}, mtie_q, 7'b0};
  assign mip_val = {{(XLEN-8){1'b0}}, mtip_sync, 7'b0};

  always_comb begin
    old_val  = '0;
    addr_hit = 1'b1;
    case (csr_addr_i)
      ADDR_MSTATUS:  old_val = mstatus_q;
      ADDR_MISA:     old_val = MISA_VAL;
      ADDR_MIE:      old_val = mie_val;
      ADDR_MTVEC:    old_val = mtvec_q;
      ADDR_MSCRATCH: old_val = mscratch_q;
      ADDR_MEPC:     old_val = mepc_q;
      ADDR_MCAUSE:   old_val = mcause_q;
      ADDR_MTVAL:    old_val = mtval_q;
      ADDR_MIP:      old_val = mip_val;
      ADDR_MCYCLE:   old_val = mcycle_q;
      ADDR_MINSTRET: old_val = minstret_q;
      ADDR_MHARTID:  old_val = HARTID;
      default:       addr_hit = 1'b0;
    endcase
  end

  assign csr_rd_data_o = old_val;
  assign csr_illegal_o = ~addr_hit;

  always_comb begin
    wdata = old_val;
    if (is_write)      wdata = src;
    else if (is_set)   wdata = old_val | src;
    else if (is_clear) wdata = old_val & ~src;
  end

  assign wr_en = csr_op & ~suppress & addr_hit;

  // Vectoring applies only to interrupts in mode 1; exceptions always go to base
  assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_target = (take_irq && (mtvec_q[1:0] == 2'b01)) ? mtvec_base + XLEN'(28)
                                                              : mtvec_base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mtip_sync_q <= '0;
    else      mtip_sync_q <= {mtip_sync_q[SYNC_STAGES-2:0], mtip_i};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_q <= MSTATUS_RESETVAL;
    end else if (take_trap) begin
      mstatus_q[BIT_MPIE]          <= mstatus_q[BIT_MIE];
      mstatus_q[BIT_MIE]           <= 1'b0;
      mstatus_q[BIT_MPP+1:BIT_MPP] <= 2'b11;
    end else if (take_mret) begin
      mstatus_q[BIT_MIE]           <= mstatus_q[BIT_MPIE];
      mstatus_q[BIT_MPIE]          <= 1'b1;
      mstatus_q[BIT_MPP+1:BIT_MPP] <= 2'b11;
    end else if (wr_en && csr_addr_i == ADDR_MSTATUS) begin
      mstatus_q <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (take_trap) begin
      mepc_q   <= ex_pc_i & ~XLEN'(3);
      mcause_q <= take_irq ? {1'b1, (XLEN-1)'(7)} : XLEN'(11);
      mtval_q  <= '0;
    end else if (wr_en) begin
      if (csr_addr_i == ADDR_MEPC)   mepc_q   <= wdata & ~XLEN'(3);
      if (csr_addr_i == ADDR_MCAUSE) mcause_q <= wdata;
      if (csr_addr_i == ADDR_MTVAL)  mtval_q  <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtvec_q    <= MTVEC_RESETVAL;
      mscratch_q <= '0;
      mtie_q     <= 1'b0;
    end else if (wr_en) begin
      if (csr_addr_i == ADDR_MTVEC)    mtvec_q    <= wdata & ~XLEN'(2);
      if (csr_addr_i == ADDR_MSCRATCH) mscratch_q <= wdata;
      if (csr_addr_i == ADDR_MIE)      mtie_q     <= wdata[7];
    end
  end

  // A CSR write to a counter takes precedence over that cycle's increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_en && csr_addr_i == ADDR_MCYCLE) mcycle_q <= wdata;
      else                                    mcycle_q <= mcycle_q + XLEN'(1);
      if (wr_en && csr_addr_i == ADDR_MINSTRET) minstret_q <= wdata;
      else if (retire_i)                        minstret_q <= minstret_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       redirect_pc_q <= '0;
    else if (take_trap)             redirect_pc_q <= trap_target;
    else if (take_mret)             redirect_pc_q <= mepc_q;
  end

  assign redirect_pc_o = redirect_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_trap || take_mret) state_d = REDIR;
      REDIR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o          = (state_q == IDLE);
    redirect_valid_o = (state_q == REDIR);
  end

endmodule

// File: tb/tb_ysyx_22050598_csr_trap_unit.sv
// Directed bench for ysyx_22050598_csr_trap_unit: a CSR access table plus
// hand-built sequences for traps, mret, interrupt sync, counters and reset.
module tb_ysyx_22050598_csr_trap_unit;

  localparam logic [5:0] RW  = 6'b100000;
  localparam logic [5:0] RS  = 6'b010000;
  localparam logic [5:0] RC  = 6'b001000;
  localparam logic [5:0] RWI = 6'b000100;
  localparam logic [5:0] RSI = 6'b000010;
  localparam logic [5:0] RCI = 6'b000001;
  localparam logic [63:0] MISA = 64'h8000_0000_0000_0100;
  localparam logic [63:0] MST0 = 64'h0000_000a_0000_1800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ready_o;
  logic [5:0]  ex_csr_bus_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [63:0] csr_reg_i = '0;
  logic [4:0]  csr_zimm_i = '0;
  logic [63:0] ex_pc_i = '0;
  logic        ex_inst_is_ecall_i = 1'b0;
  logic        ex_inst_is_mret_i = 1'b0;
  logic        retire_i = 1'b0;
  logic        mtip_i = 1'b0;
  logic [63:0] csr_rd_data_o;
  logic        csr_illegal_o;
  logic        kill_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22050598_csr_trap_unit dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ready_o(ready_o),
    .ex_csr_bus_i(ex_csr_bus_i), .csr_addr_i(csr_addr_i), .csr_reg_i(csr_reg_i),
    .csr_zimm_i(csr_zimm_i), .ex_pc_i(ex_pc_i), .ex_inst_is_ecall_i(ex_inst_is_ecall_i),
    .ex_inst_is_mret_i(ex_inst_is_mret_i), .retire_i(retire_i), .mtip_i(mtip_i),
    .csr_rd_data_o(csr_rd_data_o), .csr_illegal_o(csr_illegal_o), .kill_o(kill_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  typedef struct {
    logic        valid;
    logic [5:0]  bus;
    logic [11:0] addr;
    logic [63:0] rs1;
    logic [4:0]  zimm;
    logic [63:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [5:0] b, input logic [11:0] a,
                              input logic [63:0] r, input logic [4:0] z,
                              input logic [63:0] e, input logic il);
    vec_t t;
    t.valid = v; t.bus = b; t.addr = a; t.rs1 = r; t.zimm = z; t.exp_rd = e; t.exp_ill = il;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic v, input logic [5:0] b, input logic [11:0] a,
                       input logic [63:0] r, input logic [4:0] z, input logic [63:0] pc,
                       input logic ec, input logic mr, input logic rt);
    ex_valid_i = v; ex_csr_bus_i = b; csr_addr_i = a; csr_reg_i = r; csr_zimm_i = z;
    ex_pc_i = pc; ex_inst_is_ecall_i = ec; ex_inst_is_mret_i = mr; retire_i = rt;
    #1;
  endtask

  task automatic rd_csr(input string nm, input logic [11:0] a, input logic [63:0] exp);
    drive(1'b1, RS, a, 64'd0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk(nm, csr_rd_data_o, exp);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    tbl.push_back(mk(1, RS,  12'h300, 64'd0, 5'd0, MST0, 0));
    tbl.push_back(mk(1, RS,  12'hF14, 64'd0, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RS,  12'h301, 64'd0, 5'd0, MISA, 0));
    tbl.push_back(mk(1, RW,  12'h305, 64'h8000_0003, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RS,  12'h305, 64'd0, 5'd0, 64'h8000_0001, 0));
    tbl.push_back(mk(1, RS,  12'h305, 64'd0, 5'd0, 64'h8000_0001, 0));
    tbl.push_back(mk(1, RW,  12'h340, 64'h1234_5678_9abc_def0, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RC,  12'h340, 64'hf0, 5'd0, 64'h1234_5678_9abc_def0, 0));
    tbl.push_back(mk(1, RSI, 12'h340, 64'd0, 5'h1f, 64'h1234_5678_9abc_de00, 0));
    tbl.push_back(mk(1, RCI, 12'h340, 64'd0, 5'h03, 64'h1234_5678_9abc_de1f, 0));
    tbl.push_back(mk(1, RWI, 12'h340, 64'd0, 5'h0a, 64'h1234_5678_9abc_de1c, 0));
    tbl.push_back(mk(1, RW,  12'h340, 64'd0, 5'd0, 64'h0a, 0));
    tbl.push_back(mk(1, RW,  12'h304, 64'hffff_ffff_ffff_ffff, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RS,  12'h304, 64'd0, 5'd0, 64'h80, 0));
    tbl.push_back(mk(1, RW,  12'h301, 64'd0, 5'd0, MISA, 0));
    tbl.push_back(mk(1, RS,  12'h301, 64'd0, 5'd0, MISA, 0));
    tbl.push_back(mk(1, RW,  12'h341, 64'h1003, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RS,  12'h341, 64'd0, 5'd0, 64'h1000, 0));
    tbl.push_back(mk(1, RW,  12'hF14, 64'd5, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RS,  12'hF14, 64'd0, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RW,  12'h7C0, 64'hdead, 5'd0, 64'd0, 1));
    tbl.push_back(mk(1, RW,  12'h304, 64'd0, 5'd0, 64'h80, 0));
    tbl.push_back(mk(1, RW,  12'h344, 64'hffff, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RS,  12'h344, 64'd0, 5'd0, 64'd0, 0));
    tbl.push_back(mk(0, RW,  12'h340, 64'h55, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RS,  12'h340, 64'd0, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RW,  12'h343, 64'h77, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RS,  12'h343, 64'd0, 5'd0, 64'h77, 0));
    tbl.push_back(mk(1, RW,  12'h342, 64'd9, 5'd0, 64'd0, 0));
    tbl.push_back(mk(1, RS,  12'h342, 64'd0, 5'd0, 64'd9, 0));
    tbl.push_back(mk(1, RS,  12'h300, 64'd0, 5'd0, MST0, 0));

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst ready", 64'(ready_o), 64'd1);
    chk("rst redirect_valid", 64'(redirect_valid_o), 64'd0);
    chk("rst redirect_pc", redirect_pc_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 3; k++) rd_csr($sformatf("mcycle read %0d", k), 12'hB00, 64'(k));

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].bus, tbl[i].addr, tbl[i].rs1, tbl[i].zimm, 64'd0, 0, 0, 0);
      chk($sformatf("vec%0d rd", i), csr_rd_data_o, tbl[i].exp_rd);
      chk($sformatf("vec%0d illegal", i), 64'(csr_illegal_o), 64'(tbl[i].exp_ill));
      chk($sformatf("vec%0d kill", i), 64'(kill_o), 64'd0);
      next_cycle();
    end

    // Ecall with MIE=1, mtvec direct mode
    drive(1, RW, 12'h305, 64'h8000_0000, 5'd0, 64'd0, 0, 0, 0);
    chk("mtvec old", csr_rd_data_o, 64'h8000_0001);
    next_cycle();
    drive(1, RS, 12'h300, 64'h8, 5'd0, 64'd0, 0, 0, 0);
    next_cycle();
    drive(1, 6'd0, 12'h000, 64'd0, 5'd0, 64'h8000_0100, 1, 0, 0);
    chk("ecall kill", 64'(kill_o), 64'd0);
    next_cycle();
    drive(1, RW, 12'h340, 64'hbad, 5'd0, 64'd0, 0, 0, 0);
    chk("ecall redir valid", 64'(redirect_valid_o), 64'd1);
    chk("ecall redir pc", redirect_pc_o, 64'h8000_0000);
    chk("ecall redir ready", 64'(ready_o), 64'd0);
    next_cycle();
    drive(1, RS, 12'h341, 64'd0, 5'd0, 64'd0, 0, 0, 0);
    chk("post ecall valid low", 64'(redirect_valid_o), 64'd0);
    chk("post ecall ready", 64'(ready_o), 64'd1);
    chk("post ecall pc held", redirect_pc_o, 64'h8000_0000);
    chk("ecall mepc", csr_rd_data_o, 64'h8000_0100);
    next_cycle();
    rd_csr("ecall mcause", 12'h342, 64'd11);
    rd_csr("ecall mstatus", 12'h300, 64'h0000_000a_0000_1880);
    rd_csr("redir write ignored", 12'h340, 64'd0);
    rd_csr("ecall mtval", 12'h343, 64'd0);

    // mret
    drive(1, 6'd0, 12'h000, 64'd0, 5'd0, 64'd0, 0, 1, 0);
    chk("mret kill", 64'(kill_o), 64'd0);
    next_cycle();
    drive(0, 6'd0, 12'h000, 64'd0, 5'd0, 64'd0, 0, 0, 0);
    chk("mret redir valid", 64'(redirect_valid_o), 64'd1);
    chk("mret redir pc", redirect_pc_o, 64'h8000_0100);
    next_cycle();
    rd_csr("mret mstatus", 12'h300, 64'h0000_000a_0000_1888);

    // Timer interrupt, vectored mode
    drive(1, RW, 12'h305, 64'h8000_0001, 5'd0, 64'd0, 0, 0, 0);
    next_cycle();
    drive(1, RW, 12'h304, 64'h80, 5'd0, 64'd0, 0, 0, 0);
    next_cycle();
    mtip_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1, RS, 12'h344, 64'd0, 5'd0, 64'd0, 0, 0, 0);
      chk($sformatf("sync mip %0d", k), csr_rd_data_o, 64'd0);
      chk($sformatf("sync kill %0d", k), 64'(kill_o), 64'd0);
      next_cycle();
    end
    drive(1, RW, 12'h340, 64'h99, 5'd0, 64'h8000_0200, 0, 0, 0);
    chk("irq kill", 64'(kill_o), 64'd1);
    next_cycle();
    drive(0, 6'd0, 12'h000, 64'd0, 5'd0, 64'd0, 0, 0, 0);
    chk("irq redir valid", 64'(redirect_valid_o), 64'd1);
    chk("irq redir pc", redirect_pc_o, 64'h8000_001c);
    next_cycle();
    rd_csr("irq mcause", 12'h342, 64'h8000_0000_0000_0007);
    rd_csr("irq mepc", 12'h341, 64'h8000_0200);
    rd_csr("irq killed write", 12'h340, 64'd0);
    rd_csr("irq mip", 12'h344, 64'h80);
    rd_csr("irq mstatus", 12'h300, 64'h0000_000a_0000_1880);
    rd_csr("irq mtval", 12'h343, 64'd0);
    mtip_i = 1'b0;

    // minstret: retire pulses, then write colliding with retire
    for (int k = 0; k < 3; k++) begin
      drive(0, 6'd0, 12'h000, 64'd0, 5'd0, 64'd0, 0, 0, 1);
      next_cycle();
    end
    rd_csr("minstret count", 12'hB02, 64'd3);
    drive(1, RW, 12'hB02, 64'h100, 5'd0, 64'd0, 0, 0, 1);
    chk("minstret old", csr_rd_data_o, 64'd3);
    next_cycle();
    rd_csr("minstret write wins", 12'hB02, 64'h100);
    drive(1, RW, 12'hB00, 64'h50, 5'd0, 64'd0, 0, 0, 0);
    next_cycle();
    rd_csr("mcycle written", 12'hB00, 64'h50);
    rd_csr("mcycle counts", 12'hB00, 64'h51);

    // Reset during REDIR
    drive(1, 6'd0, 12'h000, 64'd0, 5'd0, 64'h8000_0300, 1, 0, 0);
    next_cycle();
    drive(0, 6'd0, 12'h000, 64'd0, 5'd0, 64'd0, 0, 0, 0);
    chk("pre-rst redir valid", 64'(redirect_valid_o), 64'd1);
    chk("exception ignores vector", redirect_pc_o, 64'h8000_0000);
    #1 rst = 1'b0;
    #1;
    chk("rst mid redir valid", 64'(redirect_valid_o), 64'd0);
    chk("rst mid redir ready", 64'(ready_o), 64'd1);
    chk("rst mid redir pc", redirect_pc_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    rd_csr("post rst mstatus", 12'h300, MST0);
    rd_csr("post rst mepc", 12'h341, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050598_csr_trap_unit.md
# ysyx_22050598_csr_trap_unit

Parametrised machine-mode CSR file and trap controller for the EXU stage. It adds to the four-register CSR datapath the mscratch, mie, mip, mtval, misa, mhartid, mcycle and minstret CSRs. It adds correct mstatus MIE/MPIE/MPP stacking on trap entry and mret, a synchronised timer-interrupt input, and vectored mtvec mode. A registered redirect/flush handshake replaces the combinational PC mux.

## Interface
- XLEN, 64: CSR and data width.
- MSTATUS_RESETVAL, 64'h0000_000a_0000_1800: mstatus reset value.
- MTVEC_RESETVAL, 0: mtvec reset value.
- HARTID, 0: constant read from mhartid.
- MISA_VAL, 64'h8000_0000_0000_0100: constant read from misa (RV64I).
- SYNC_STAGES, 2: depth of the mtip synchroniser, minimum 2.
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_valid_i  in  1  an instruction is presented this cycle.
- ready_o  out  1  the unit accepts an instruction this cycle.
- ex_csr_bus_i  in  6  one-hot CSR operation: [5]=csrrw, [4]=csrrs, [3]=csrrc, [2]=csrrwi, [1]=csrrsi, [0]=csrrci.
- csr_addr_i  in  12  CSR address.
- csr_reg_i  in  XLEN  rs1 value.
- csr_zimm_i  in  5  zimm field, zero-extended internally.
- ex_pc_i  in  XLEN  PC of the presented instruction.
- ex_inst_is_ecall_i, ex_inst_is_mret_i  in  1  each  decoded ecall / mret.
- retire_i  in  1  one instruction retired this cycle; drives minstret.
- mtip_i  in  1  timer interrupt, asynchronous to clk.
- csr_rd_data_o  out  XLEN  old CSR value for rd; combinational.
- csr_illegal_o  out  1  the access targets an unimplemented address; combinational.
- kill_o  out  1  the presented instruction must not commit; combinational.
- redirect_valid_o  out  1  PC redirect request; registered.
- redirect_pc_o  out  XLEN  redirect target; registered.

## Operation
- Accept condition: fire = ex_valid_i & ready_o. Every action below requires fire.
- Priority: interrupt, then ecall, then mret, then CSR operation.
- Interrupt taken when mstatus.MIE & mie.MTIE & mip.MTIP.
  - kill_o=1.
  - mepc ← ex_pc_i.
  - mcause ← {1'b1, 63'd7}.
  - mtval ← 0.
- Ecall:
  - kill_o=0.
  - mepc ← ex_pc_i.
  - mcause ← 11.
  - mtval ← 0.
- Trap entry (interrupt or ecall) also updates mstatus: MPIE←MIE, MIE←0, MPP←2'b11.
- Trap target:
  - mtvec mode = mtvec[1:0]; base = {mtvec[XLEN-1:2], 2'b00}.
  - Mode 0, or any exception: target = base.
  - Mode 1 with an interrupt: target = base + 4*7.
- mret: MIE←MPIE, MPIE←1, MPP←2'b11; target = mepc.
- CSR write value:
  - rw: src.
  - rs: old | src.
  - rc: old & ~src.
  - src = csr_reg_i for the register forms, zero-extended zimm for the immediate forms.
- CSR write suppression:
  - csrrs/csrrc/csrrsi/csrrci with src==0 do not write.
  - Writes to misa, mhartid and mip are ignored.
- Write masks:
  - mtvec bit1 is forced to 0.
  - mepc[1:0] is forced to 0.
  - mie keeps only bit 7 (MTIE); other bits read 0.
  - mip reads {mtip_sync, 7'b0} at bit 7; other bits read 0.
- Address map:
  - 0x300 mstatus, 0x301 misa, 0x304 mie, 0x305 mtvec.
  - 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip.
  - 0xB00 mcycle, 0xB02 minstret, 0xF14 mhartid.
  - Any other address: csr_rd_data_o=0, csr_illegal_o=1, no write.
- mcycle increments every cycle out of reset.
- minstret increments on retire_i.
- Counter collision: a CSR write to a counter in the same cycle overrides that cycle's increment. Both counters wrap at 2^XLEN.
- FSM: IDLE, REDIR.
  - IDLE → REDIR on fire with interrupt, ecall or mret.
  - REDIR → IDLE unconditionally.
  - ready_o = (state==IDLE).

## Timing
- Reset values:
  - mstatus = MSTATUS_RESETVAL.
  - mtvec = MTVEC_RESETVAL.
  - All other writable CSRs = 0; synchroniser flops = 0.
  - state = IDLE.
  - Outputs: ready_o=1, redirect_valid_o=0, redirect_pc_o=0.
- csr_rd_data_o, csr_illegal_o and kill_o are valid in the fire cycle. All CSR updates land at the end of the fire cycle.
- redirect_valid_o is high exactly one cycle, the cycle after a trap or mret fire. redirect_pc_o holds its value until the next redirect.
- ready_o is 0 in the REDIR cycle. ex_valid_i asserted during REDIR is ignored.
- mtip_i reaches mip.MTIP SYNC_STAGES cycles after it changes. Interrupt evaluation uses the synchronised value only.
- Reset asserted mid-REDIR: redirect_valid_o drops immediately and state returns to IDLE.
- A read of mcycle returns the pre-increment value of that cycle.

## Test plan
- Reset → mstatus reads 0xa00001800; mhartid reads HARTID; ready_o=1; mcycle counts 0, 1, 2 on successive reads one cycle apart.
- csrrw mtvec←0x8000_0003 then csrrs mtvec with rs1=0 → the second access returns 0x8000_0001 and mtvec is unchanged.
- mtvec=0x8000_0000, ecall at pc=0x8000_0100 → mepc=0x8000_0100, mcause=11, MIE=0, MPIE=old MIE; next cycle redirect_valid_o=1 with 0x8000_0000 and ready_o=0.
- mret after that ecall → MIE restored; redirect to 0x8000_0100 one cycle later.
- MIE=1, MTIE=1, mtvec=0x8000_0001, mtip_i rises → no trap for 2 cycles. On the next fire: kill_o=1, mcause=0x8000_0000_0000_0007, redirect to 0x8000_001c.
- Address 0x7C0 access → csr_illegal_o=1, rd 0, no state change; minstret write colliding with retire_i=1 → the written value wins.
